// File: rtl/fp_round_pipe.sv
// Two-stage rounding pipeline for a small unsigned float format, with
// valid/ready handshaking on both sides and a saturating count of saturated results.
module fp_round_pipe #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SIG_W-1:0] in_sig,
  input  logic             in_guard,
  input  logic             in_sticky,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_count
);

  function automatic logic round_inc(input logic [1:0] mode, input logic guard,
                                     input logic sticky, input logic lsb);
    case (mode)
      2'b00:   return guard;
      2'b10:   return guard & (sticky | lsb);
      default: return 1'b0;
    endcase
  endfunction

  // Returns {sat, exp, sig}; a carry out of the significand bumps the exponent,
  // and with no exponent headroom left the value clamps at the all-ones maximum.
  function automatic logic [EXP_W+SIG_W:0] round_apply(input logic [EXP_W-1:0] e,
                                                       input logic [SIG_W-1:0] s,
                                                       input logic inc);
    logic             sat;
    logic [EXP_W-1:0] re;
    logic [SIG_W-1:0] rs;
    sat = 1'b0;
    re  = e;
    rs  = s;
    if (inc) begin
      if (s != '1) begin
        rs = s + 1'b1;
      end else if (e != '1) begin
        re = e + 1'b1;
        rs = {1'b1, {(SIG_W-1){1'b0}}};
      end else begin
        sat = 1'b1;
      end
    end
    return {sat, re, rs};
  endfunction

  function automatic logic [CNT_W-1:0] sat_incr(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  logic                   vld_p1, vld_p2;
  logic [EXP_W-1:0]       exp_p1;
  logic [SIG_W-1:0]       sig_p1;
  logic                   inc_p1;
  logic                   acc_p0, adv_p1;
  logic [EXP_W+SIG_W:0]   res_p1;

  assign in_ready  = !vld_p1 || !vld_p2 || out_ready;
  assign acc_p0    = in_valid && in_ready;
  assign adv_p1    = vld_p1 && (!vld_p2 || out_ready);
  assign out_valid = vld_p2;
  assign res_p1    = round_apply(exp_p1, sig_p1, inc_p1);

  // Stage 1: operands and the increment decision, captured at acceptance
  always_ff @(posedge clk) begin
    if (acc_p0) begin
      exp_p1 <= in_exp;
      sig_p1 <= in_sig;
      inc_p1 <= round_inc(in_mode, in_guard, in_sticky, in_sig[0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (acc_p0) begin
      vld_p1 <= 1'b1;
    end else if (adv_p1) begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage 2: final result register driving the output port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      out_exp   <= '0;
      out_sig   <= '0;
      out_sat   <= 1'b0;
      sat_count <= '0;
    end else begin
      if (adv_p1) begin
        vld_p2                      <= 1'b1;
        {out_sat, out_exp, out_sig} <= res_p1;
      end else if (out_ready) begin
        vld_p2 <= 1'b0;
      end
      if (vld_p2 && out_ready && out_sat) begin
        sat_count <= sat_incr(sat_count);
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Bench for fp_round_pipe: directed literal cases, stall/reset scenarios and
// randomized traffic scored against a queue-based arithmetic model.
module tb_fp_round_pipe;
  localparam int EW = 3, SW = 4, CW = 8;
  localparam int EW2 = 5, SW2 = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_guard, in_sticky;
  logic [EW-1:0] in_exp;
  logic [SW-1:0] in_sig;
  logic [1:0]    in_mode;
  logic          out_valid, out_ready, out_sat;
  logic [EW-1:0] out_exp;
  logic [SW-1:0] out_sig;
  logic [CW-1:0] sat_count;

  logic           d2_in_valid, d2_in_ready, d2_in_guard, d2_in_sticky;
  logic [EW2-1:0] d2_in_exp;
  logic [SW2-1:0] d2_in_sig;
  logic [1:0]     d2_in_mode;
  logic           d2_out_valid, d2_out_ready, d2_out_sat;
  logic [EW2-1:0] d2_out_exp;
  logic [SW2-1:0] d2_out_sig;
  logic [CW-1:0]  d2_sat_count;

  fp_round_pipe #(.EXP_W(EW), .SIG_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_sig(in_sig), .in_guard(in_guard), .in_sticky(in_sticky),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_sig(out_sig), .out_sat(out_sat), .sat_count(sat_count));

  fp_round_pipe #(.EXP_W(EW2), .SIG_W(SW2), .CNT_W(CW)) dut2 (
    .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_exp(d2_in_exp), .in_sig(d2_in_sig), .in_guard(d2_in_guard), .in_sticky(d2_in_sticky),
    .in_mode(d2_in_mode), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .out_exp(d2_out_exp), .out_sig(d2_out_sig), .out_sat(d2_out_sat), .sat_count(d2_sat_count));

  typedef struct {int e; int s; int sat;} res_t;

  int   total = 0, passed = 0;
  res_t q[$];
  int   mcnt = 0;
  bit   held = 0;
  int   he, hs, hsat;
  int   d2_n = 0;
  res_t d2r;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act == want) passed++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, want);
  endtask

  // Rounding as plain integer arithmetic: add the increment, then resolve overflow.
  function automatic res_t model(input int ew, input int sw, input int e, input int s,
                                 input int g, input int st, input int m);
    res_t r;
    int inc;
    int emax = (1 << ew) - 1;
    int smax = (1 << sw) - 1;
    inc = (m == 0) ? g : (m == 2) ? (g & (st | (s & 1))) : 0;
    r.e = e; r.s = s; r.sat = 0;
    if (inc != 0) begin
      if (s + 1 <= smax) r.s = s + 1;
      else if (e + 1 <= emax) begin r.e = e + 1; r.s = 1 << (sw - 1); end
      else r.sat = 1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcnt = 0;
      held = 0;
    end else begin
      chk("in_ready", int'(in_ready), (q.size() < 2 || out_ready) ? 1 : 0);
      if (held && out_valid) begin
        chk("stall_exp", int'(out_exp), he);
        chk("stall_sig", int'(out_sig), hs);
        chk("stall_sat", int'(out_sat), hsat);
      end
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", int'(out_valid), 0);
        else begin
          chk("out_exp", int'(out_exp), q[0].e);
          chk("out_sig", int'(out_sig), q[0].s);
          chk("out_sat", int'(out_sat), q[0].sat);
          chk("sat_count", int'(sat_count), mcnt);
          if (out_ready) begin
            if (q[0].sat != 0 && mcnt < (1 << CW) - 1) mcnt++;
            void'(q.pop_front());
          end
        end
      end
      held = out_valid && !out_ready;
      he = int'(out_exp); hs = int'(out_sig); hsat = int'(out_sat);
      if (in_valid && in_ready)
        q.push_back(model(EW, SW, int'(in_exp), int'(in_sig), int'(in_guard),
                          int'(in_sticky), int'(in_mode)));
    end
  end

  always @(negedge clk) begin
    if (rst) d2_n = 0;
    else if (d2_out_valid && d2_out_ready) begin
      d2r = model(EW2, SW2, (1 << EW2) - 1, (1 << SW2) - 1, 1, 0, 0);
      chk("d2_exp", int'(d2_out_exp), d2r.e);
      chk("d2_sig", int'(d2_out_sig), d2r.s);
      chk("d2_sat", int'(d2_out_sat), d2r.sat);
      chk("d2_sat_count", int'(d2_sat_count), (d2_n < 255) ? d2_n : 255);
      d2_n++;
    end
  end

  task automatic send_chk(input string nm, input int e, input int s, input int g,
                          input int st, input int m, input int we, input int ws,
                          input int wsat);
    @(posedge clk); #1;
    in_valid = 1'b1; in_exp = EW'(e); in_sig = SW'(s);
    in_guard = 1'(g); in_sticky = 1'(st); in_mode = 2'(m);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_exp"}, int'(out_exp), we);
    chk({nm, "_sig"}, int'(out_sig), ws);
    chk({nm, "_sat"}, int'(out_sat), wsat);
  endtask

  initial begin
    res_t r;
    int   w, cyc, i;
    bit   saw_block;
    in_valid = 0; in_exp = '0; in_sig = '0; in_guard = 0; in_sticky = 0; in_mode = '0;
    out_ready = 1;
    d2_in_valid = 0; d2_in_exp = '0; d2_in_sig = '0; d2_in_guard = 0; d2_in_sticky = 0;
    d2_in_mode = '0; d2_out_ready = 1;

    r = model(3, 4, 7, 15, 1, 0, 0);
    chk("pin_sat", r.sat, 1);
    chk("pin_sat_e", r.e, 7);
    r = model(3, 4, 2, 15, 1, 0, 0);
    chk("pin_carry_e", r.e, 3);
    chk("pin_carry_s", r.s, 8);
    r = model(3, 4, 4, 6, 1, 0, 2);
    chk("pin_rne_tie_even", r.s, 6);
    r = model(3, 4, 4, 7, 1, 0, 2);
    chk("pin_rne_tie_odd", r.s, 8);

    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sat_count", int'(sat_count), 0);
    chk("rst_out_exp", int'(out_exp), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rel_in_ready", int'(in_ready), 1);

    send_chk("sat", 7, 15, 1, 0, 0, 7, 15, 1);
    @(posedge clk); #1;
    chk("sat_count_one", int'(sat_count), 1);
    send_chk("carry", 2, 15, 1, 0, 0, 3, 8, 0);
    send_chk("trunc", 2, 15, 1, 0, 1, 2, 15, 0);
    send_chk("rsvd", 2, 15, 1, 1, 3, 2, 15, 0);
    send_chk("rne_even", 4, 6, 1, 0, 2, 4, 6, 0);
    send_chk("rne_odd", 4, 7, 1, 0, 2, 4, 8, 0);
    send_chk("rne_sticky", 4, 6, 1, 1, 2, 4, 7, 0);
    send_chk("max_noinc", 7, 15, 0, 1, 0, 7, 15, 0);

    // Eight back-to-back inputs with the consumer stalled on cycles 3..6
    cyc = 0; i = 0; saw_block = 0; w = 0;
    while (i < 8 && w < 100) begin
      @(posedge clk); #1;
      cyc++; w++;
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid = 1; in_exp = EW'(i); in_sig = SW'(i * 2 + 1);
      in_guard = 1; in_sticky = 0; in_mode = 2'b00;
      #1;
      if (in_ready) i++;
      else saw_block = 1;
    end
    chk("burst_sent", i, 8);
    chk("burst_in_ready_dropped", int'(saw_block), 1);
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    w = 0;
    while (q.size() != 0 && w < 50) begin @(posedge clk); w++; end
    chk("burst_drain", q.size(), 0);

    repeat (1500) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 10) < 7;
      in_exp    = ($urandom % 3 == 0) ? '1 : EW'($urandom);
      in_sig    = ($urandom % 3 == 0) ? '1 : SW'($urandom);
      in_guard  = 1'($urandom);
      in_sticky = 1'($urandom);
      in_mode   = 2'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    w = 0;
    while (q.size() != 0 && w < 50) begin @(posedge clk); w++; end
    chk("rand_drain", q.size(), 0);

    // Fill both stages behind a stalled consumer, then reset mid-flight
    @(posedge clk); #1;
    in_valid = 1; out_ready = 0; in_exp = '1; in_sig = '1; in_guard = 1; in_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 0;
    rst = 1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_sat_count", int'(sat_count), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 0; out_ready = 1;
    chk("midrst_rel_in_ready", int'(in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_stale", int'(out_valid), 0);

    d2_in_valid = 1; d2_in_exp = '1; d2_in_sig = '1; d2_in_guard = 1; d2_in_mode = 2'b00;
    w = 0;
    while (d2_n < 300 && w < 400) begin @(posedge clk); w++; end
    #1 d2_in_valid = 0;
    chk("d2_count_reached", (d2_n >= 300) ? 1 : 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("d2_sat_count_final", int'(d2_sat_count), 255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
